mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one external memory port between the CPU instruction bus (ibus, read-only) and data bus (dbus, read/write).
- Sits between the bit_mips core's ibus_*/dbus_* ports and a single SRAM/bridge with a req/ready handshake.
- Converts variable memory latency into per-bus stall signals.
- Arbitration: dbus has priority over ibus, with a starvation guard for ibus and a per-access timeout.

Parameters:
- STARVE_LIMIT, 4: consecutive dbus grants allowed while ibus is pending before ibus is forced a grant; range 1..15.
- TIMEOUT_CYCLES, 255: cycles in XFER without mem_ready before the access is aborted; 0 disables the timeout; maximum 65535.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ibus_addr  in  32  instruction fetch address
- ibus_read  in  1  fetch request (level, held by core while stalled)
- ibus_data  out  32  fetched word, valid in ibus completion cycle
- ibus_stall  out  1  ibus request pending, not completing this cycle
- dbus_addr  in  32  data address
- dbus_read  in  1  load request (level)
- dbus_write  in  1  store request (level)
- dbus_wdata  in  32  store data
- dbus_byteenable  in  4  store byte lanes
- dbus_data  out  32  load data, valid in dbus completion cycle
- dbus_stall  out  1  dbus request pending, not completing this cycle
- mem_req  out  1  memory access active
- mem_we  out  1  1 = write
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_byteenable  out  4  memory byte lanes
- mem_rdata  in  32  memory read data, sampled when mem_ready=1
- mem_ready  in  1  memory completes current access this cycle
- bus_error  out  1  one-cycle pulse in completion cycle of a timed-out access

Behaviour:
- Reset (async): state=IDLE; mem_req, mem_we, bus_error = 0; mem_addr, mem_wdata, ibus_data, dbus_data = 0; mem_byteenable=0; starve counter=0; timeout counter=0.
- Reset asserted mid-transfer drops mem_req immediately; the in-flight access is abandoned.
- State IDLE:
  - Evaluate requests; no request means stay in IDLE.
  - Winner: dbus if (dbus_read|dbus_write) and not (ibus_read and starve==STARVE_LIMIT); otherwise ibus if ibus_read.
  - On a grant, register owner, addr, we, wdata and byteenable into mem_* outputs, then go to XFER.
  - mem_req rises on the cycle after the request is first seen.
- Per-bus fields at grant:
  - dbus: mem_we=dbus_write (write wins if read and write are both high); mem_byteenable=dbus_byteenable for writes, 4'hF for reads.
  - ibus: mem_we=0; mem_byteenable=4'hF.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when dbus is granted while ibus_read=1.
  - Clears when ibus is granted.
  - Unchanged when dbus is granted with ibus idle.
- State XFER:
  - mem_req=1; mem_* outputs stable.
  - On mem_ready=1: capture mem_rdata into the owner's data register (reads only; a write leaves dbus_data unchanged); clear mem_req and mem_we; clear timeout counter; go to DONE.
  - Otherwise, if TIMEOUT_CYCLES != 0, increment the timeout counter. On reaching TIMEOUT_CYCLES: owner data register=0, set error flag, clear mem_req, go to DONE.
- State DONE (one cycle):
  - The owner's stall is 0 and the owner's data output is valid.
  - bus_error=1 if the access timed out.
  - Next state is IDLE, so new arbitration happens the cycle after DONE.
- Stalls (combinational):
  - ibus_stall = ibus_read & ~(state==DONE & owner==IBUS).
  - dbus_stall = (dbus_read|dbus_write) & ~(state==DONE & owner==DBUS).
  - Stalls follow this rule even during reset.
- Minimum access: 3 cycles with request-to-completion (IDLE, XFER with mem_ready=1, DONE). Each extra mem_ready=0 cycle adds one.
- Request withdrawn during XFER (pipeline flush): the memory access still completes and the DONE cycle occurs, but the result is discarded with no side effects. Address or data changing mid-transfer is ignored because the values are latched.
- mem_ready while not in XFER is ignored.
- Data outputs hold their value until the next completion for the same bus.

Test Plan:
- Single fetch: ibus_read=1, ibus_addr=0xBFC00000, mem_ready=1 in the first XFER cycle, mem_rdata=0x24080001 -> mem_req high for 1 cycle with mem_addr=0xBFC00000, mem_we=0, be=4'hF; ibus_stall low in cycle 2 with ibus_data=0x24080001.
- Store with wait states: dbus_write=1, addr=0x80000010, wdata=0xDEADBEEF, be=4'b0011, mem_ready delayed 3 cycles -> mem_req held 4 cycles with we=1, be=4'b0011; dbus_stall low only in DONE; dbus_data unchanged.
- Simultaneous requests: ibus_read and dbus_read both high in IDLE -> dbus served first; ibus served in the next arbitration; starve counter=1 then 0.
- Starvation with STARVE_LIMIT=4: continuous dbus_read and ibus_read -> grant sequence D,D,D,D,I,D,...
- Timeout with TIMEOUT_CYCLES=8 and mem_ready stuck at 0 on a dbus load -> after 8 XFER cycles, DONE with dbus_data=0, bus_error pulse of 1 cycle, and dbus_stall low that cycle.
- Reset mid-XFER -> mem_req=0 asynchronously; after release the arbiter is in IDLE, counters are 0, and a pending request is re-granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the instruction bus and the data bus.
// dbus wins arbitration unless ibus has been passed over STARVE_LIMIT times
// in a row. Each access runs IDLE -> XFER -> DONE, and the DONE cycle is the
// single cycle in which the owning bus sees its stall drop.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ibus_addr,
  input  logic        ibus_read,
  output logic [31:0] ibus_data,
  output logic        ibus_stall,
  input  logic [31:0] dbus_addr,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [31:0] dbus_wdata,
  input  logic [3:0]  dbus_byteenable,
  output logic [31:0] dbus_data,
  output logic        dbus_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_error
);
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

  localparam logic        OWN_I   = 1'b0;
  localparam logic        OWN_D   = 1'b1;
  localparam logic [3:0]  SL      = 4'(STARVE_LIMIT);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  state_t      state, state_nx;
  logic        owner;
  logic [3:0]  starve;
  logic [15:0] tcnt;
  logic        cancel;   // owner dropped its request during this access

  logic ireq, dreq, pick_d, owner_req, keep;
  logic grant, xfer_ok, xfer_to;

  assign ireq      = ibus_read;
  assign dreq      = dbus_read | dbus_write;
  assign pick_d    = dreq & ~(ireq & (starve == SL));
  assign owner_req = (owner == OWN_D) ? dreq : ireq;
  // A flushed access still runs to completion but must leave no trace.
  assign keep      = ~cancel & owner_req;

  // Stalls are purely combinational so they track requests even in reset.
  assign ibus_stall = ireq & ~((state == DONE) & (owner == OWN_I));
  assign dbus_stall = dreq & ~((state == DONE) & (owner == OWN_D));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and per-cycle event strobes.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    xfer_ok  = 1'b0;
    xfer_to  = 1'b0;
    case (state)
      IDLE: if (ireq | dreq) begin
        grant    = 1'b1;
        state_nx = XFER;
      end
      XFER: if (mem_ready) begin
        xfer_ok  = 1'b1;
        state_nx = DONE;
      end else if (TO_EN && (tcnt == TO_LAST)) begin
        xfer_to  = 1'b1;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant latching, memory-side outputs, result capture and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner          <= OWN_I;
      starve         <= '0;
      tcnt           <= '0;
      cancel         <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_byteenable <= '0;
      ibus_data      <= '0;
      dbus_data      <= '0;
      bus_error      <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      if (grant) begin
        mem_req <= 1'b1;
        tcnt    <= '0;
        cancel  <= 1'b0;
        if (pick_d) begin
          owner          <= OWN_D;
          mem_we         <= dbus_write;
          mem_addr       <= dbus_addr;
          mem_wdata      <= dbus_wdata;
          mem_byteenable <= dbus_write ? dbus_byteenable : 4'hF;
          if (ireq && (starve != SL)) starve <= starve + 4'd1;
        end else begin
          owner          <= OWN_I;
          mem_we         <= 1'b0;
          mem_addr       <= ibus_addr;
          mem_wdata      <= '0;
          mem_byteenable <= 4'hF;
          starve         <= '0;
        end
      end else if (state == XFER) begin
        if (!owner_req) cancel <= 1'b1;
        if (xfer_ok) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          tcnt    <= '0;
          if (keep && !mem_we) begin
            if (owner == OWN_D) dbus_data <= mem_rdata;
            else                ibus_data <= mem_rdata;
          end
        end else if (xfer_to) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          tcnt    <= '0;
          if (keep) begin
            bus_error <= 1'b1;
            if (owner == OWN_D) dbus_data <= '0;
            else                ibus_data <= '0;
          end
        end else if (TO_EN) begin
          tcnt <= tcnt + 16'd1;
        end
      end
    end
  end
endmodule
